// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared types and mode constants for the VGA raster timing
//               generator and its clients. Holds the FSM state encoding,
//               a mode descriptor record, standard mode constant sets and
//               the sync inactive-level helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Raster FSM: INIT waits for the first pixel tick, RUN scans the raster.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } vga_state_t;

    // One complete video mode: horizontal values in pixels, vertical in lines.
    // Polarity 0 = active-low sync, 1 = active-high sync.
    typedef struct packed {
        int   h_active;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_active;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic hs_pol;
        logic vs_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640,  h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480,  v_fp: 10, v_sync: 2,   v_bp: 33,
        hs_pol:   1'b0, vs_pol: 1'b0
    };

    localparam vga_mode_t MODE_800X600_60 = '{
        h_active: 800,  h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600,  v_fp: 1,  v_sync: 4,   v_bp: 23,
        hs_pol:   1'b1, vs_pol: 1'b1
    };

    localparam vga_mode_t MODE_1024X768_60 = '{
        h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
        v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
        hs_pol:   1'b0, vs_pol: 1'b0
    };

    // Level a sync line rests at when not in its sync interval.
    function automatic logic sync_inactive(input logic pol);
        return ~pol;
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster timing bundle produced by vga_timing_gen and consumed
//               by pixel-generation blocks.
//               pix_en      - one-cycle strobe, new pixel outputs valid
//               HS, VS      - sync at configured polarity
//               x, y        - raw raster position including blanking
//               blank       - outside the active area
//               line_start  - pix_en qualified with x == 0
//               frame_start - pix_en qualified with x == 0 and y == 0
//               frame_cnt   - frames completed since reset (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CW = 11,
    parameter int FW = 8
);
    logic          pix_en;
    logic          HS;
    logic          VS;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          blank;
    logic          line_start;
    logic          frame_start;
    logic [FW-1:0] frame_cnt;

    modport master (
        output pix_en, HS, VS, x, y, blank, line_start, frame_start, frame_cnt
    );

    modport slave (
        input  pix_en, HS, VS, x, y, blank, line_start, frame_start, frame_cnt
    );
endinterface : vga_timing_gen_if
`default_nettype wire

// File: rtl/vga_pix_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : vga_pix_prescaler
// Description : Integer rate divider. Counter pre runs 0..PRESCALE-1 and
//               wraps; tick is high while pre sits at its last value, so the
//               edge that wraps the counter is the tick edge. PRESCALE = 1
//               gives a permanently high tick.
//               Ports: CLK (in), RST_N (in, sync active-low), tick (out).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick
);

    localparam int               c_pw   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pw-1:0] c_last = c_pw'(PRESCALE - 1);

    logic [c_pw-1:0] r_pre;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pre <= '0;
        end else if (r_pre == c_last) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_pw'(1);
        end
    end

    assign tick = (r_pre == c_last);

endmodule : vga_pix_prescaler
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator. A prescaler derives
//               the pixel tick from CLK; a two-state FSM walks the raster and
//               every output is registered on the tick edge so position,
//               sync, blank and markers stay mutually aligned.
//               Ports: CLK (in), RST_N (in, sync active-low),
//                      vid (vga_timing_gen_if.master, all raster outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = MODE_640X480_60.h_active,
    parameter int H_FP     = MODE_640X480_60.h_fp,
    parameter int H_SYNC   = MODE_640X480_60.h_sync,
    parameter int H_BP     = MODE_640X480_60.h_bp,
    parameter int V_ACTIVE = MODE_640X480_60.v_active,
    parameter int V_FP     = MODE_640X480_60.v_fp,
    parameter int V_SYNC   = MODE_640X480_60.v_sync,
    parameter int V_BP     = MODE_640X480_60.v_bp,
    parameter bit HS_POL   = MODE_640X480_60.hs_pol,
    parameter bit VS_POL   = MODE_640X480_60.vs_pol,
    parameter int PRESCALE = 4,
    parameter int CW       = 11,
    parameter int FW       = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    vga_timing_gen_if.master  vid
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync intervals are held as inclusive bounds so that a mode whose total
    // is exactly 2^CW never needs a CW-bit value equal to the total.
    localparam logic [CW-1:0] c_h_last    = CW'(c_h_total - 1);
    localparam logic [CW-1:0] c_v_last    = CW'(c_v_total - 1);
    localparam logic [CW-1:0] c_h_act     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_v_act     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_hs_first  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_hs_last   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] c_vs_first  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_vs_last   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          c_hs_off    = sync_inactive(HS_POL);
    localparam logic          c_vs_off    = sync_inactive(VS_POL);

    // ------------------------------------------------------------------
    // Pixel-rate strobe
    // ------------------------------------------------------------------
    logic w_tick;

    vga_pix_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    vga_state_t     r_state;
    vga_state_t     w_state_nx;

    logic [CW-1:0]  r_x;
    logic [CW-1:0]  r_y;
    logic [FW-1:0]  r_frame_cnt;
    logic           r_pix_en;
    logic           r_hs;
    logic           r_vs;
    logic           r_blank;
    logic           r_line_start;
    logic           r_frame_start;

    logic [CW-1:0]  w_x_nx;
    logic [CW-1:0]  w_y_nx;
    logic [FW-1:0]  w_frame_cnt_nx;
    logic           w_load;
    logic           w_hs_nx;
    logic           w_vs_nx;
    logic           w_blank_nx;
    logic           w_origin_nx;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next position. INIT loads the origin on its first tick so pixel (0,0)
    // of frame 0 is shown rather than skipped; RUN advances on every tick.
    always_comb begin
        w_state_nx     = r_state;
        w_x_nx         = r_x;
        w_y_nx         = r_y;
        w_frame_cnt_nx = r_frame_cnt;
        w_load         = 1'b0;

        case (r_state)
            ST_INIT: begin
                if (w_tick) begin
                    w_x_nx     = '0;
                    w_y_nx     = '0;
                    w_load     = 1'b1;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tick) begin
                    w_load = 1'b1;
                    if (r_x == c_h_last) begin
                        w_x_nx = '0;
                        if (r_y == c_v_last) begin
                            w_y_nx         = '0;
                            w_frame_cnt_nx = r_frame_cnt + FW'(1);
                        end else begin
                            w_y_nx = r_y + CW'(1);
                        end
                    end else begin
                        w_x_nx = r_x + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nx = ST_INIT;
            end
        endcase
    end

    // Decodes are taken from the position about to be loaded, so sync and
    // blank land on the same edge as the coordinates they describe.
    always_comb begin
        w_blank_nx  = (w_x_nx >= c_h_act) || (w_y_nx >= c_v_act);
        w_hs_nx     = ((w_x_nx >= c_hs_first) && (w_x_nx <= c_hs_last)) ? HS_POL : c_hs_off;
        w_vs_nx     = ((w_y_nx >= c_vs_first) && (w_y_nx <= c_vs_last)) ? VS_POL : c_vs_off;
        w_origin_nx = (w_x_nx == '0) && (w_y_nx == '0);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_cnt   <= '0;
            r_pix_en      <= 1'b0;
            r_hs          <= c_hs_off;
            r_vs          <= c_vs_off;
            r_blank       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Strobes last exactly one cycle; everything else holds between ticks.
            r_pix_en      <= w_load;
            r_line_start  <= w_load && (w_x_nx == '0);
            r_frame_start <= w_load && w_origin_nx;
            if (w_load) begin
                r_x         <= w_x_nx;
                r_y         <= w_y_nx;
                r_frame_cnt <= w_frame_cnt_nx;
                r_hs        <= w_hs_nx;
                r_vs        <= w_vs_nx;
                r_blank     <= w_blank_nx;
            end
        end
    end

    assign vid.pix_en      = r_pix_en;
    assign vid.HS          = r_hs;
    assign vid.VS          = r_vs;
    assign vid.x           = r_x;
    assign vid.y           = r_y;
    assign vid.blank       = r_blank;
    assign vid.line_start  = r_line_start;
    assign vid.frame_start = r_frame_start;
    assign vid.frame_cnt   = r_frame_cnt;

endmodule : vga_timing_gen
`default_nettype wire
